// File: rtl/uart_recv_flit_if.sv
// Flit hand-off channel between the UART flit receiver and the router inject port.
// The receiver drives valid/data and the consumer drives ready.
interface uart_recv_flit_if #(
    parameter int WIDTH = 66
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_recv_flit.sv
// UART 8N1 receiver that reassembles 9-byte frames into 66-bit NoC flits and
// offers each flit through a single holding register on a valid/ready channel.
module uart_recv_flit #(
    parameter int WIDTH        = 66,
    parameter int CLK_FREQ     = 50000000,
    parameter int UART_BPS     = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_rxd,
    uart_recv_flit_if.master  flit_if,
    output logic [3:0]        byte_cnt,
    output logic              frame_err,
    output logic              rx_timeout,
    output logic              overrun
);
    localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [15:0]     HALF_M1 = 16'(BPS_CNT / 2 - 1);
    localparam logic [15:0]     BIT_M1  = 16'(BPS_CNT - 1);
    localparam logic [TO_W-1:0] TO_M1   = TO_W'(TO_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg, state_next;
    logic [15:0]       clk_cnt_reg, clk_cnt_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [7:0]        rx_byte_reg, rx_byte_next;
    logic              rx_meta_reg, rxs_reg, rxs_d_reg;
    logic [TO_W-1:0]   idle_cnt_reg;
    logic [63:0]       asm_reg, asm_next;
    logic [WIDTH-1:0]  flit_data_reg;
    logic              flit_valid_reg;
    logic              start_edge, byte_ok, byte_bad, complete, timeout_hit;

    assign start_edge  = rxs_d_reg & ~rxs_reg;
    assign complete    = byte_ok && (byte_cnt == 4'd8);
    assign timeout_hit = (state_reg == IDLE) && (byte_cnt != 4'd0) && !start_edge
                         && (idle_cnt_reg == TO_M1);

    assign flit_if.valid = flit_valid_reg;
    assign flit_if.data  = flit_data_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            rx_byte_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            rx_byte_reg <= rx_byte_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg + 16'd1;
        bit_idx_next = bit_idx_reg;
        rx_byte_next = rx_byte_reg;
        byte_ok      = 1'b0;
        byte_bad     = 1'b0;
        case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                if (start_edge)
                    state_next = START;
            end
            START: begin
                // Half a bit in: a line already back high was only a glitch.
                if (clk_cnt_reg == HALF_M1) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = rxs_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_reg == BIT_M1) begin
                    clk_cnt_next = '0;
                    rx_byte_next = {rxs_reg, rx_byte_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7)
                        state_next = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_reg == BIT_M1) begin
                    clk_cnt_next = '0;
                    byte_ok      = rxs_reg;
                    byte_bad     = !rxs_reg;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One byte lane per low flit byte; lane k captures when byte k is accepted.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign asm_next[8*gi +: 8] = (byte_ok && byte_cnt == 4'(gi)) ? rx_byte_reg
                                                                    : asm_reg[8*gi +: 8];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_reg    <= 1'b1;
            rxs_reg        <= 1'b1;
            rxs_d_reg      <= 1'b1;
            idle_cnt_reg   <= '0;
            asm_reg        <= '0;
            byte_cnt       <= '0;
            frame_err      <= 1'b0;
            rx_timeout     <= 1'b0;
            overrun        <= 1'b0;
            flit_valid_reg <= 1'b0;
            flit_data_reg  <= '0;
        end else begin
            rx_meta_reg <= uart_rxd;
            rxs_reg     <= rx_meta_reg;
            rxs_d_reg   <= rxs_reg;
            asm_reg     <= asm_next;
            frame_err   <= byte_bad;
            rx_timeout  <= timeout_hit;
            overrun     <= complete && flit_valid_reg && !flit_if.ready;

            if (state_reg != IDLE || byte_cnt == 4'd0 || start_edge || timeout_hit)
                idle_cnt_reg <= '0;
            else
                idle_cnt_reg <= idle_cnt_reg + TO_W'(1);

            if (byte_bad || timeout_hit)
                byte_cnt <= '0;
            else if (byte_ok)
                byte_cnt <= (byte_cnt == 4'd8) ? 4'd0 : byte_cnt + 4'd1;

            // Holding register: a new flit only lands if the slot is free or draining.
            if (complete && (!flit_valid_reg || flit_if.ready)) begin
                flit_valid_reg <= 1'b1;
                flit_data_reg  <= {rx_byte_reg[1:0], asm_reg};
            end else if (flit_valid_reg && flit_if.ready) begin
                flit_valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_recv_flit.sv
// Directed bench for uart_recv_flit: serialises 8N1 frames at 16 clocks per bit and
// checks flit delivery, glitch rejection, frame errors, timeout, overrun and reset.
module tb_uart_recv_flit;
    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic [3:0] byte_cnt;
    logic       frame_err, rx_timeout, overrun;

    uart_recv_flit_if #(.WIDTH(66)) flit_if ();

    uart_recv_flit #(
        .WIDTH(66), .CLK_FREQ(16), .UART_BPS(1), .TIMEOUT_BITS(20)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_rxd   (uart_rxd),
        .flit_if    (flit_if.master),
        .byte_cnt   (byte_cnt),
        .frame_err  (frame_err),
        .rx_timeout (rx_timeout),
        .overrun    (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    localparam logic [65:0] FLIT_A = 66'h3_0123_4567_89AB_CDEF;
    localparam logic [65:0] FLIT_B = 66'h1_FFFF_0000_AAAA_5555;
    localparam logic [65:0] FLIT_C = 66'h2_DEAD_BEEF_CAFE_F00D;
    localparam logic [65:0] FLIT_D = 66'h0_1111_2222_3333_4444;

    int vectors     = 0;
    int miscompares = 0;

    int          n_ferr, n_tout, n_ovr, n_valid, n_xfer;
    logic [65:0] last_xfer;

    // Passive monitor: counts pulse cycles and records every accepted flit.
    always @(negedge sys_clk) begin
        if (frame_err)  n_ferr++;
        if (rx_timeout) n_tout++;
        if (overrun)    n_ovr++;
        if (flit_if.valid) n_valid++;
        if (flit_if.valid && flit_if.ready) begin
            n_xfer++;
            last_xfer = flit_if.data;
            $display("xfer #%0d data=%h", n_xfer, flit_if.data);
        end
    end

    task automatic clear_mon();
        n_ferr = 0; n_tout = 0; n_ovr = 0; n_valid = 0; n_xfer = 0;
        last_xfer = '0;
    endtask

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [7:0] flit_byte(input logic [65:0] f, input int k);
        logic [7:0] b;
        if (k < 8) b = f[8*k +: 8];
        else       b = {6'b0, f[65:64]};
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        @(negedge sys_clk);
        uart_rxd = 1'b0;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (16) @(negedge sys_clk);
        end
        uart_rxd = stop_val;
        repeat (16) @(negedge sys_clk);
        uart_rxd = 1'b1;
    endtask

    task automatic send_flit(input logic [65:0] f);
        for (int k = 0; k < 9; k++)
            send_byte(flit_byte(f, k), 1'b1);
    endtask

    task automatic test_reset();
        flit_if.ready = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        clear_mon();
        check("reset_valid",      66'(flit_if.valid), 66'd0);
        check("reset_data",       flit_if.data,       66'd0);
        check("reset_byte_cnt",   66'(byte_cnt),      66'd0);
        check("reset_pulses",     66'({frame_err, rx_timeout, overrun}), 66'd0);
    endtask

    task automatic test_single_flit();
        clear_mon();
        for (int k = 0; k < 9; k++) begin
            send_byte(flit_byte(FLIT_A, k), 1'b1);
            if (byte_cnt !== 4'((k + 1) % 9)) begin
                miscompares++;
                $display("FAIL t1_byte_cnt after byte %0d: got %0d expected %0d",
                         k, byte_cnt, (k + 1) % 9);
            end
            vectors++;
        end
        repeat (4) @(negedge sys_clk);
        check("t1_valid_cycles", 66'(n_valid), 66'd1);
        check("t1_xfers",        66'(n_xfer),  66'd1);
        check("t1_data",         last_xfer,    FLIT_A);
        check("t1_err_pulses",   66'(n_ferr + n_tout + n_ovr), 66'd0);
    endtask

    task automatic test_glitch();
        clear_mon();
        @(negedge sys_clk);
        uart_rxd = 1'b0;
        repeat (4) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (200) @(negedge sys_clk);
        check("t2_byte_cnt", 66'(byte_cnt), 66'd0);
        check("t2_flags",    66'(n_ferr + n_tout + n_ovr + n_valid), 66'd0);
    endtask

    task automatic test_frame_err();
        clear_mon();
        for (int k = 0; k < 3; k++)
            send_byte(flit_byte(FLIT_A, k), 1'b1);
        check("t3_byte_cnt_pre", 66'(byte_cnt), 66'd3);
        send_byte(flit_byte(FLIT_A, 3), 1'b0);
        check("t3_frame_err",    66'(n_ferr),   66'd1);
        check("t3_byte_cnt_err", 66'(byte_cnt), 66'd0);
        send_flit(FLIT_B);
        repeat (4) @(negedge sys_clk);
        check("t3_xfers",        66'(n_xfer),   66'd1);
        check("t3_data",         last_xfer,     FLIT_B);
        check("t3_frame_err_end", 66'(n_ferr),  66'd1);
    endtask

    task automatic test_timeout();
        clear_mon();
        for (int k = 0; k < 5; k++)
            send_byte(flit_byte(FLIT_C, k), 1'b1);
        check("t4_byte_cnt_pre", 66'(byte_cnt), 66'd5);
        repeat (300) @(negedge sys_clk);
        check("t4_no_early_to",  66'(n_tout),   66'd0);
        repeat (40) @(negedge sys_clk);
        check("t4_timeout",      66'(n_tout),   66'd1);
        check("t4_byte_cnt",     66'(byte_cnt), 66'd0);
        send_flit(FLIT_D);
        repeat (4) @(negedge sys_clk);
        check("t4_xfers",        66'(n_xfer),   66'd1);
        check("t4_data",         last_xfer,     FLIT_D);
    endtask

    task automatic test_overrun();
        clear_mon();
        @(posedge sys_clk); #1 flit_if.ready = 1'b0;
        send_flit(FLIT_A);
        check("t5_valid_a",  66'(flit_if.valid), 66'd1);
        check("t5_data_a",   flit_if.data,       FLIT_A);
        check("t5_ovr_pre",  66'(n_ovr),         66'd0);
        send_flit(FLIT_B);
        check("t5_overrun",  66'(n_ovr),         66'd1);
        check("t5_data_hold", flit_if.data,      FLIT_A);
        @(posedge sys_clk); #1 flit_if.ready = 1'b1;
        repeat (6) @(negedge sys_clk);
        check("t5_xfers",    66'(n_xfer),        66'd1);
        check("t5_xfer_data", last_xfer,         FLIT_A);
        check("t5_valid_end", 66'(flit_if.valid), 66'd0);
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        @(posedge sys_clk); #1 flit_if.ready = 1'b0;
        send_flit(FLIT_C);
        check("t6_valid_pre", 66'(flit_if.valid), 66'd1);
        for (int k = 0; k < 6; k++)
            send_byte(flit_byte(FLIT_D, k), 1'b1);
        @(negedge sys_clk);
        uart_rxd = 1'b0;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            uart_rxd = flit_byte(FLIT_D, 6)[i];
            repeat (16) @(negedge sys_clk);
        end
        sys_rst_n = 1'b0;
        #1;
        check("t6_rst_valid",    66'(flit_if.valid), 66'd0);
        check("t6_rst_data",     flit_if.data,       66'd0);
        check("t6_rst_byte_cnt", 66'(byte_cnt),      66'd0);
        uart_rxd      = 1'b1;
        flit_if.ready = 1'b1;
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        clear_mon();
        send_flit(FLIT_D);
        repeat (4) @(negedge sys_clk);
        check("t6_xfers", 66'(n_xfer), 66'd1);
        check("t6_data",  last_xfer,   FLIT_D);
    endtask

    initial begin
        clear_mon();
        flit_if.ready = 1'b1;
        test_reset();
        test_single_flit();
        test_glitch();
        test_frame_err();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
